// File: rtl/pc_pipe_gen.sv
// Program-counter generator with a parametrised chain of delayed-PC stages.
// It handles redirect, trap and return flushes and keeps an exception-PC register.
module pc_pipe_gen #(
  parameter int              XLEN        = 32,
  parameter int              DEPTH       = 2,
  parameter int              INSTR_BYTES = 4,
  parameter logic [XLEN-1:0] RESET_VAL   = '0,
  parameter logic [XLEN-1:0] TRAP_VEC    = XLEN'(32'h0000_0100)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  stall_i,
  input  logic                  incr_pc_i,
  input  logic                  redirect_i,
  input  logic [XLEN-1:0]       redirect_target_i,
  input  logic                  trap_i,
  input  logic                  ret_i,
  output logic [XLEN-1:0]       pc_o,
  output logic                  pc_valid_o,
  output logic [DEPTH*XLEN-1:0] pc_pipe_o,
  output logic [DEPTH-1:0]      pipe_valid_o,
  output logic [XLEN-1:0]       epc_o,
  output logic                  misalign_o
);

  localparam logic [XLEN-1:0] LOW_MASK = XLEN'(INSTR_BYTES - 1);
  localparam logic [XLEN-1:0] STEP     = XLEN'(INSTR_BYTES);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic            pc_valid_q;
  logic            misalign_q, misalign_d;
  logic [XLEN-1:0] pipe_q [DEPTH];
  logic [XLEN-1:0] pipe_d [DEPTH];
  logic [DEPTH-1:0] v_q, v_d;
  logic            flush;

  assign flush = trap_i | redirect_i | ret_i;

  // NOTE: every comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    pc_d  = pc_q;
    epc_d = epc_q;
    if (trap_i) begin
      pc_d  = TRAP_VEC;
      epc_d = pipe_q[DEPTH-1];
    end else if (redirect_i) begin
      pc_d = redirect_target_i & ~LOW_MASK;
    end else if (ret_i) begin
      pc_d = epc_q;
    end else if (!stall_i && incr_pc_i && pc_valid_q) begin
      pc_d = pc_q + STEP;
    end
  end

  // A masked (trapped) redirect never reports misalignment.
  assign misalign_d = redirect_i & ~trap_i & (|(redirect_target_i & LOW_MASK));

  always_comb begin
    pipe_d = pipe_q;
    v_d    = v_q;
    if (flush) begin
      v_d = '0;
    end else if (!stall_i) begin
      pipe_d[0] = pc_q;
      v_d[0]    = pc_valid_q & incr_pc_i;
      for (int k = 1; k < DEPTH; k++) begin
        pipe_d[k] = pipe_q[k-1];
        v_d[k]    = v_q[k-1];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q       <= RESET_VAL;
      epc_q      <= RESET_VAL;
      pc_valid_q <= 1'b0;
      misalign_q <= 1'b0;
      v_q        <= '0;
      // NOTE: the delay chain is a small register array, so its addresses have a defined reset value.
      for (int k = 0; k < DEPTH; k++) pipe_q[k] <= RESET_VAL;
    end else begin
      pc_q       <= pc_d;
      epc_q      <= epc_d;
      pc_valid_q <= 1'b1;
      misalign_q <= misalign_d;
      v_q        <= v_d;
      pipe_q     <= pipe_d;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_pipe_out
    assign pc_pipe_o[g*XLEN +: XLEN] = pipe_q[g];
  end

  assign pc_o         = pc_q;
  assign pc_valid_o   = pc_valid_q;
  assign pipe_valid_o = v_q;
  assign epc_o        = epc_q;
  assign misalign_o   = misalign_q;

endmodule

// File: tb/tb_pc_pipe_gen.sv
// Bench for pc_pipe_gen: a 32-bit/2-stage build and a 16-bit/4-stage build share the same stimulus.
// A behavioural model is compared against both builds every cycle, alongside hand-computed literals.
module tb_pc_pipe_gen;

  logic        clk = 1'b0;
  logic        rst, stall, incr, redirect, trap, ret;
  logic [31:0] target;

  logic [31:0] pc_a, epc_a;
  logic        pcv_a, mis_a;
  logic [63:0] pipe_a;
  logic [1:0]  pv_a;
  logic [15:0] pc_b, epc_b;
  logic        pcv_b, mis_b;
  logic [63:0] pipe_b;
  logic [3:0]  pv_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pc_pipe_gen #(.XLEN(32), .DEPTH(2), .INSTR_BYTES(4),
                .RESET_VAL(32'h0), .TRAP_VEC(32'h0000_0100)) u_a (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .incr_pc_i(incr),
    .redirect_i(redirect), .redirect_target_i(target), .trap_i(trap), .ret_i(ret),
    .pc_o(pc_a), .pc_valid_o(pcv_a), .pc_pipe_o(pipe_a), .pipe_valid_o(pv_a),
    .epc_o(epc_a), .misalign_o(mis_a));

  pc_pipe_gen #(.XLEN(16), .DEPTH(4), .INSTR_BYTES(4),
                .RESET_VAL(16'h0), .TRAP_VEC(16'h0100)) u_b (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .incr_pc_i(incr),
    .redirect_i(redirect), .redirect_target_i(target[15:0]), .trap_i(trap), .ret_i(ret),
    .pc_o(pc_b), .pc_valid_o(pcv_b), .pc_pipe_o(pipe_b), .pipe_valid_o(pv_b),
    .epc_o(epc_b), .misalign_o(mis_b));

  // Behavioural model state, one set per build (index 0 = 32-bit/2-stage, 1 = 16-bit/4-stage).
  logic [31:0] m_pc   [2];
  logic [31:0] m_epc  [2];
  logic        m_pcv  [2];
  logic        m_mis  [2];
  logic [31:0] m_pipe [2][8];
  logic        m_v    [2][8];

  function automatic int dep(input int i);
    return (i == 0) ? 2 : 4;
  endfunction

  function automatic logic [31:0] wmask(input int i);
    return (i == 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_pc[i]  <= 32'h0;
      m_epc[i] <= 32'h0;
      m_pcv[i] <= 1'b0;
      m_mis[i] <= 1'b0;
      for (int k = 0; k < 8; k++) begin
        m_pipe[i][k] <= 32'h0;
        m_v[i][k]    <= 1'b0;
      end
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      int          d;
      logic [31:0] tgt;
      d   = dep(i);
      tgt = target & wmask(i);
      if (trap || redirect || ret) begin
        for (int k = 0; k < 8; k++) m_v[i][k] <= 1'b0;
      end else if (!stall) begin
        m_pipe[i][0] <= m_pc[i];
        m_v[i][0]    <= m_pcv[i] & incr;
        for (int k = 1; k < d; k++) begin
          m_pipe[i][k] <= m_pipe[i][k-1];
          m_v[i][k]    <= m_v[i][k-1];
        end
      end
      if (trap) begin
        m_pc[i]  <= 32'h0000_0100;
        m_epc[i] <= m_pipe[i][d-1];
      end else if (redirect) begin
        m_pc[i] <= tgt & ~32'h3;
      end else if (ret) begin
        m_pc[i] <= m_epc[i];
      end else if (!stall && incr && m_pcv[i]) begin
        m_pc[i] <= (m_pc[i] + 32'd4) & wmask(i);
      end
      m_mis[i] <= redirect && !trap && (tgt[1:0] != 2'b00);
      m_pcv[i] <= 1'b1;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else     model_step();
  end

  task automatic cmp_inst(input int i, input logic [31:0] pc, input logic pcv,
                          input logic [7:0] pv, input logic [255:0] pipe,
                          input logic [31:0] epc, input logic mis);
    string       tag;
    logic [7:0]  epv;
    logic [255:0] sh;
    int          w;
    tag = (i == 0) ? "a" : "b";
    w   = (i == 0) ? 32 : 16;
    epv = '0;
    for (int k = 0; k < dep(i); k++) epv[k] = m_v[i][k];
    check({tag, ".pc"}, pc, m_pc[i]);
    check({tag, ".pc_valid"}, {31'b0, pcv}, {31'b0, m_pcv[i]});
    check({tag, ".pipe_valid"}, {24'b0, pv}, {24'b0, epv});
    check({tag, ".epc"}, epc, m_epc[i]);
    check({tag, ".misalign"}, {31'b0, mis}, {31'b0, m_mis[i]});
    for (int k = 0; k < dep(i); k++) begin
      sh = pipe >> (k * w);
      check($sformatf("%s.pipe%0d", tag, k), sh[31:0] & wmask(i), m_pipe[i][k]);
    end
  endtask

  always @(negedge clk) begin
    cmp_inst(0, pc_a, pcv_a, {6'b0, pv_a}, {192'b0, pipe_a}, epc_a, mis_a);
    cmp_inst(1, {16'b0, pc_b}, pcv_b, {4'b0, pv_b}, {192'b0, pipe_b}, {16'b0, epc_b}, mis_b);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic inc, input logic rd,
                       input logic tr, input logic rt, input logic [31:0] tgt);
    stall = st; incr = inc; redirect = rd; trap = tr; ret = rt; target = tgt;
  endtask

  initial begin
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 32'h0);
    #1 rst = 1'b1;
    #1;
    check("rst.pc", pc_a, 32'h0);
    check("rst.pc_valid", {31'b0, pcv_a}, 32'h0);
    check("rst.pipe_valid_b", {28'b0, pv_b}, 32'h0);
    check("rst.misalign", {31'b0, mis_a}, 32'h0);
    #10;
    rst = 1'b0;
    drive(0, 1, 0, 0, 0, 32'h0);

    // Fill: first edge only validates the PC, then it advances by 4.
    tick();
    check("fill.pc0", pc_a, 32'h0);
    check("fill.valid0", {31'b0, pcv_a}, 32'h1);
    check("fill.pv0", {30'b0, pv_a}, 32'h0);
    tick();
    check("fill.pc1", pc_a, 32'h4);
    check("fill.pv1", {30'b0, pv_a}, 32'h1);
    tick();
    check("fill.pc2", pc_a, 32'h8);
    check("fill.pv2", {30'b0, pv_a}, 32'h3);
    check("fill.pipe1", pipe_a[63:32], 32'h0);
    tick();
    tick();
    check("fill.pc4", pc_a, 32'h10);
    check("fill.pipe0", pipe_a[31:0], 32'hC);
    check("fill.pipe1b", pipe_a[63:32], 32'h8);
    repeat (4) tick();

    // Stall at 0x20 with incr held high.
    drive(1, 1, 0, 0, 0, 32'h0);
    repeat (3) tick();
    check("stall.pc", pc_a, 32'h20);
    check("stall.pipe0", pipe_a[31:0], 32'h1C);
    check("stall.pipe1", pipe_a[63:32], 32'h18);
    check("stall.pv", {30'b0, pv_a}, 32'h3);
    drive(0, 1, 0, 0, 0, 32'h0);
    tick();
    check("resume.pc", pc_a, 32'h24);
    check("resume.pipe0", pipe_a[31:0], 32'h20);
    check("resume.pipe1", pipe_a[63:32], 32'h1C);

    // Misaligned redirect while stalled.
    drive(1, 1, 1, 0, 0, 32'h1002);
    tick();
    check("redir.pc", pc_a, 32'h1000);
    check("redir.pv", {30'b0, pv_a}, 32'h0);
    check("redir.misalign", {31'b0, mis_a}, 32'h1);
    drive(0, 1, 0, 0, 0, 32'h0);
    tick();
    check("redir.misalign_pulse", {31'b0, mis_a}, 32'h0);
    check("redir.pc_next", pc_a, 32'h1004);
    check("redir.pv_next", {30'b0, pv_a}, 32'h1);

    // Trap masks a simultaneous misaligned redirect, then return.
    drive(0, 1, 1, 0, 0, 32'h38);
    tick();
    drive(0, 1, 0, 0, 0, 32'h0);
    repeat (4) tick();
    check("pretrap.pipe1", pipe_a[63:32], 32'h40);
    drive(0, 1, 1, 1, 0, 32'h2002);
    tick();
    check("trap.pc", pc_a, 32'h100);
    check("trap.epc", epc_a, 32'h40);
    check("trap.pv", {30'b0, pv_a}, 32'h0);
    check("trap.misalign", {31'b0, mis_a}, 32'h0);
    drive(0, 0, 0, 0, 1, 32'h0);
    tick();
    check("ret.pc", pc_a, 32'h40);
    check("ret.epc", epc_a, 32'h40);
    drive(1, 1, 0, 1, 1, 32'h0);
    tick();
    check("trapret.pc", pc_a, 32'h100);

    // Wrap at the top of the address space.
    drive(0, 1, 1, 0, 0, 32'hFFFF_FFFC);
    tick();
    check("wrap.pre_a", pc_a, 32'hFFFF_FFFC);
    check("wrap.pre_b", {16'b0, pc_b}, 32'hFFFC);
    drive(0, 1, 0, 0, 0, 32'h0);
    tick();
    check("wrap.a", pc_a, 32'h0);
    check("wrap.b", {16'b0, pc_b}, 32'h0);

    // Bubbles through the 4-stage build.
    drive(0, 1, 1, 0, 0, 32'h200);
    tick();
    drive(0, 1, 0, 0, 0, 32'h0); tick();
    drive(0, 0, 0, 0, 0, 32'h0); tick();
    drive(0, 1, 0, 0, 0, 32'h0); tick();
    drive(0, 0, 0, 0, 0, 32'h0); tick();
    check("bubble.pv_b", {28'b0, pv_b}, 32'hA);
    check("bubble.pipe3_b", {16'b0, pipe_b[63:48]}, 32'h200);
    check("bubble.pipe0_b", {16'b0, pipe_b[15:0]}, 32'h208);
    check("bubble.pc_b", {16'b0, pc_b}, 32'h208);
    drive(0, 1, 0, 0, 0, 32'h0); tick();
    drive(1, 1, 0, 0, 0, 32'h0); tick();
    drive(0, 1, 0, 0, 0, 32'h0); tick();
    drive(0, 0, 0, 0, 0, 32'h0); tick();
    drive(0, 1, 0, 0, 0, 32'h0); tick();
    tick();

    // Asynchronous reset between clock edges.
    #2 rst = 1'b1;
    #1;
    check("arst.pc_a", pc_a, 32'h0);
    check("arst.valid_a", {31'b0, pcv_a}, 32'h0);
    check("arst.pv_a", {30'b0, pv_a}, 32'h0);
    check("arst.epc_a", epc_a, 32'h0);
    check("arst.pc_b", {16'b0, pc_b}, 32'h0);
    check("arst.pipe3_b", {16'b0, pipe_b[63:48]}, 32'h0);
    check("arst.pv_b", {28'b0, pv_b}, 32'h0);
    #2 rst = 1'b0;
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
